// File: rtl/cms_ctrl_axil_bridge.sv
// AXI4-Lite register front end that stages a 64-bit word and address and issues timed CMS write-enable pulses.
// Optional feature: define CMS_CTRL_TLAST_REG_EN to make tlast_interval writable at 0x14.
module cms_ctrl_axil_bridge #(
  parameter int          AXIL_ADDR_WIDTH = 5,
  parameter int          PULSE_CYCLES    = 2,
  parameter logic [31:0] TLAST_DEFAULT   = 32'd1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [31:0]                s_axil_wdata,
  input  logic [3:0]                 s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [31:0]                s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic [7:0]                 ctrl_addr,
  output logic [63:0]                ctrl_wdata,
  output logic                       ctrl_write_enable,
  output logic [31:0]                tlast_interval,
  output logic                       busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [AXIL_ADDR_WIDTH-1:0] A_LO     = AXIL_ADDR_WIDTH'(5'h00);
  localparam logic [AXIL_ADDR_WIDTH-1:0] A_HI     = AXIL_ADDR_WIDTH'(5'h04);
  localparam logic [AXIL_ADDR_WIDTH-1:0] A_ADDR   = AXIL_ADDR_WIDTH'(5'h08);
  localparam logic [AXIL_ADDR_WIDTH-1:0] A_CMD    = AXIL_ADDR_WIDTH'(5'h0C);
  localparam logic [AXIL_ADDR_WIDTH-1:0] A_STATUS = AXIL_ADDR_WIDTH'(5'h10);
  localparam logic [AXIL_ADDR_WIDTH-1:0] WORD_MSK = ~AXIL_ADDR_WIDTH'(3);

  state_t                       state;
  logic [3:0]                   pulse_cnt;
  logic [15:0]                  cmd_count;
  logic [31:0]                  wdata_lo;
  logic [31:0]                  wdata_hi;
  logic [7:0]                   stage_addr;
  logic                         wr_rdy;
  logic                         rd_rdy;
  logic [AXIL_ADDR_WIDTH-1:0]   waddr;
  logic [AXIL_ADDR_WIDTH-1:0]   raddr;
  logic                         wr_hs;
  logic                         rd_hs;
  logic                         wr_ok;
  logic                         rd_ok;
  logic [31:0]                  rd_data;
  logic                         cmd_fire;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur, input logic [31:0] nxt,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = nxt[8*i +: 8];
    return res;
  endfunction

  assign s_axil_awready = wr_rdy;
  assign s_axil_wready  = wr_rdy;
  assign s_axil_arready = rd_rdy;

  assign waddr    = s_axil_awaddr & WORD_MSK;
  assign raddr    = s_axil_araddr & WORD_MSK;
  assign wr_hs    = wr_rdy && s_axil_awvalid && s_axil_wvalid;
  assign rd_hs    = rd_rdy && s_axil_arvalid;
  // busy is still high on the last PULSE cycle, so a CMD landing there is dropped
  assign cmd_fire = wr_hs && (waddr == A_CMD) && (|s_axil_wstrb) && !busy;

`ifdef CMS_CTRL_TLAST_REG_EN
  localparam logic [AXIL_ADDR_WIDTH-1:0] A_TLAST = AXIL_ADDR_WIDTH'(5'h14);
  logic [31:0] tlast_reg;
  logic [31:0] tlast_nxt;

  assign tlast_nxt      = byte_merge(tlast_reg, s_axil_wdata, s_axil_wstrb);
  assign tlast_interval = tlast_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      tlast_reg <= TLAST_DEFAULT;
    else if (wr_hs && waddr == A_TLAST)
      tlast_reg <= (tlast_nxt == 32'd0) ? 32'd1 : tlast_nxt;
  end
`else
  assign tlast_interval = TLAST_DEFAULT;
`endif

  always_comb begin
    wr_ok = 1'b1;
    case (waddr)
      A_LO, A_HI, A_ADDR: wr_ok = 1'b1;
      A_CMD:              wr_ok = !((|s_axil_wstrb) && busy);
`ifdef CMS_CTRL_TLAST_REG_EN
      A_TLAST:            wr_ok = 1'b1;
`endif
      default:            wr_ok = 1'b0;
    endcase
  end

  always_comb begin
    rd_data = 32'd0;
    rd_ok   = 1'b1;
    case (raddr)
      A_LO:     rd_data = wdata_lo;
      A_HI:     rd_data = wdata_hi;
      A_ADDR:   rd_data = {24'd0, stage_addr};
      A_CMD:    rd_data = 32'd0;
      A_STATUS: rd_data = {cmd_count, 15'd0, busy};
`ifdef CMS_CTRL_TLAST_REG_EN
      A_TLAST:  rd_data = tlast_reg;
`endif
      default:  rd_ok = 1'b0;
    endcase
  end

  // Write channel: AW and W accepted together, one outstanding response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_rdy        <= 1'b0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      wdata_lo      <= 32'd0;
      wdata_hi      <= 32'd0;
      stage_addr    <= 8'd0;
    end else begin
      wr_rdy <= s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid && !wr_rdy;
      if (wr_hs) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        case (waddr)
          A_LO:    wdata_lo <= byte_merge(wdata_lo, s_axil_wdata, s_axil_wstrb);
          A_HI:    wdata_hi <= byte_merge(wdata_hi, s_axil_wdata, s_axil_wstrb);
          A_ADDR:  if (s_axil_wstrb[0]) stage_addr <= s_axil_wdata[7:0];
          default: ;
        endcase
      end else if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: read mux sampled at acceptance, payload held until rready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_rdy        <= 1'b0;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= 32'd0;
      s_axil_rresp  <= RESP_OKAY;
    end else begin
      rd_rdy <= s_axil_arvalid && !s_axil_rvalid && !rd_rdy;
      if (rd_hs) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_ok ? rd_data : 32'd0;
        s_axil_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

  // Command sequencer: one settle cycle, then PULSE_CYCLES of enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      pulse_cnt         <= 4'd0;
      cmd_count         <= 16'd0;
      ctrl_addr         <= 8'd0;
      ctrl_wdata        <= 64'd0;
      ctrl_write_enable <= 1'b0;
      busy              <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            ctrl_addr  <= stage_addr;
            ctrl_wdata <= {wdata_hi, wdata_lo};
            busy       <= 1'b1;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          ctrl_write_enable <= 1'b1;
          pulse_cnt         <= 4'(PULSE_CYCLES - 1);
          state             <= ST_PULSE;
        end
        ST_PULSE: begin
          if (pulse_cnt == 4'd0) begin
            ctrl_write_enable <= 1'b0;
            busy              <= 1'b0;
            cmd_count         <= cmd_count + 16'd1;
            state             <= ST_IDLE;
          end else begin
            pulse_cnt <= pulse_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cms_ctrl_axil_bridge.sv
// Randomized bench for cms_ctrl_axil_bridge against a cycle-indexed register/command model.
// Honours CMS_CTRL_TLAST_REG_EN the same way as the design.
module tb_cms_ctrl_axil_bridge;

  localparam int          P    = 2;
  localparam logic [31:0] TDEF = 32'd1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;
  logic [4:0]  s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [7:0]  ctrl_addr;
  logic [63:0] ctrl_wdata;
  logic        ctrl_write_enable;
  logic [31:0] tlast_interval;
  logic        busy;

  cms_ctrl_axil_bridge #(.AXIL_ADDR_WIDTH(5), .PULSE_CYCLES(P), .TLAST_DEFAULT(TDEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_write_enable(ctrl_write_enable),
    .tlast_interval(tlast_interval), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int rises = 0;
  logic en_d = 1'b0;

  // Reference state: register contents plus the cycle window of the latest command
  logic [31:0] m_lo, m_hi, m_tlast;
  logic [7:0]  m_addr;
  logic [15:0] m_count;
  logic [7:0]  m_ca_prev, m_ca_cur;
  logic [63:0] m_cw_prev, m_cw_cur;
  int          m_ceff, p_start, p_end;
  bit          have_pulse;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_lo = '0; m_hi = '0; m_addr = '0; m_count = '0; m_tlast = TDEF;
    m_ca_prev = '0; m_ca_cur = '0; m_cw_prev = '0; m_cw_cur = '0;
    m_ceff = 0; p_start = 0; p_end = 0; have_pulse = 1'b0;
  endfunction

  function automatic bit busy_at(input int c);
    return have_pulse && (c >= p_start - 1) && (c <= p_end);
  endfunction

  function automatic logic [15:0] cnt_at(input int c);
    return (have_pulse && c <= p_end) ? m_count - 16'd1 : m_count;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d,
                                             input logic [3:0] s, input int c);
    logic [1:0] r;
    logic [31:0] t;
    r = 2'b00;
    case ({a[4:2], 2'b00})
      5'h00: m_lo = strb_merge(m_lo, d, s);
      5'h04: m_hi = strb_merge(m_hi, d, s);
      5'h08: if (s[0]) m_addr = d[7:0];
      5'h0C: if (s != 4'd0) begin
        if (busy_at(c)) r = 2'b10;
        else begin
          m_ca_prev = m_ca_cur; m_cw_prev = m_cw_cur;
          m_ca_cur = m_addr;    m_cw_cur = {m_hi, m_lo};
          m_ceff = c + 1; p_start = c + 2; p_end = c + 1 + P;
          have_pulse = 1'b1;
          m_count = m_count + 16'd1;
        end
      end
`ifdef CMS_CTRL_TLAST_REG_EN
      5'h14: begin
        t = strb_merge(m_tlast, d, s);
        m_tlast = (t == 0) ? 32'd1 : t;
      end
`endif
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  function automatic void model_read(input logic [4:0] a, input int c, output logic [31:0] d, output logic [1:0] r);
    r = 2'b00;
    d = 32'd0;
    case ({a[4:2], 2'b00})
      5'h00: d = m_lo;
      5'h04: d = m_hi;
      5'h08: d = {24'd0, m_addr};
      5'h0C: d = 32'd0;
      5'h10: d = {cnt_at(c), 15'd0, busy_at(c)};
`ifdef CMS_CTRL_TLAST_REG_EN
      5'h14: d = m_tlast;
`endif
      default: r = 2'b10;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("enable", 64'(ctrl_write_enable), 64'(have_pulse && cyc >= p_start && cyc <= p_end));
      check("busy", 64'(busy), 64'(busy_at(cyc)));
      check("ctrl_addr", 64'(ctrl_addr), 64'((cyc >= m_ceff) ? m_ca_cur : m_ca_prev));
      check("ctrl_wdata", ctrl_wdata, (cyc >= m_ceff) ? m_cw_cur : m_cw_prev);
      if (ctrl_write_enable && !en_d) rises++;
    end
    en_d = ctrl_write_enable;
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    int n;
    int acc;
    logic [1:0] er;
    @(negedge clk);
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axil_awready && n < 20);
    if (!s_axil_awready) begin
      check("aw_timeout", 64'(0), 64'(1));
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      return;
    end
    check("wready", 64'(s_axil_wready), 64'(1));
    acc = cyc;
    er = model_write(a, d, s, acc);
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axil_bvalid && n < 20);
    check("b_latency", 64'(n), 64'(1));
    check("bresp", 64'(s_axil_bresp), 64'(er));
    if (hold > 0) begin s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_hold", 64'(s_axil_bvalid), 64'(1));
      check("bresp_hold", 64'(s_axil_bresp), 64'(er));
      check("aw_blocked", 64'(s_axil_awready), 64'(0));
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b1;
    @(posedge clk); #1;
    s_axil_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, input int hold, output logic [31:0] got);
    int n;
    int acc;
    logic [31:0] ed;
    logic [1:0] er;
    got = '0;
    @(negedge clk);
    s_axil_araddr = a; s_axil_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axil_arready && n < 20);
    if (!s_axil_arready) begin
      check("ar_timeout", 64'(0), 64'(1));
      s_axil_arvalid = 1'b0;
      return;
    end
    acc = cyc;
    model_read(a, acc, ed, er);
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axil_rvalid && n < 20);
    check("r_latency", 64'(n), 64'(1));
    check("rdata", 64'(s_axil_rdata), 64'(ed));
    check("rresp", 64'(s_axil_rresp), 64'(er));
    got = s_axil_rdata;
    if (hold > 0) s_axil_arvalid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", 64'(s_axil_rvalid), 64'(1));
      check("rdata_hold", 64'(s_axil_rdata), 64'(ed));
      check("ar_blocked", 64'(s_axil_arready), 64'(0));
    end
    s_axil_arvalid = 1'b0; s_axil_rready = 1'b1;
    @(posedge clk); #1;
    s_axil_rready = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [4:0]  a;
    int base;
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(s_axil_awready), 64'(0));
    check("rst_wready", 64'(s_axil_wready), 64'(0));
    check("rst_bvalid", 64'(s_axil_bvalid), 64'(0));
    check("rst_bresp", 64'(s_axil_bresp), 64'(0));
    check("rst_arready", 64'(s_axil_arready), 64'(0));
    check("rst_rvalid", 64'(s_axil_rvalid), 64'(0));
    check("rst_rresp", 64'(s_axil_rresp), 64'(0));
    check("rst_rdata", 64'(s_axil_rdata), 64'(0));
    check("rst_ctrl_addr", 64'(ctrl_addr), 64'(0));
    check("rst_ctrl_wdata", ctrl_wdata, 64'(0));
    check("rst_enable", 64'(ctrl_write_enable), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tlast", 64'(tlast_interval), 64'(TDEF));
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Basic command, then a second CMD landing on the final pulse cycle
    axi_write(5'h00, 32'hDEADBEEF, 4'hF, 0);
    axi_write(5'h04, 32'h01234567, 4'hF, 0);
    axi_write(5'h08, 32'h00000005, 4'hF, 0);
    base = rises;
    axi_write(5'h0C, 32'h00000001, 4'hF, 0);
    check("cmd_addr", 64'(ctrl_addr), 64'h05);
    check("cmd_wdata", ctrl_wdata, 64'h01234567DEADBEEF);
    axi_write(5'h0C, 32'h00000001, 4'hF, 0);
    repeat (6) @(negedge clk);
    check("one_pulse", 64'(rises - base), 64'(1));
    axi_read(5'h10, 0, rd);
    check("status_after_cmd", 64'(rd), 64'h00010000);

    axi_write(5'h04, 32'hAABBCCDD, 4'b0010, 0);
    axi_read(5'h04, 0, rd);
    check("strb_hi", 64'(rd), 64'h0123CC67);

    axi_read(5'h18, 5, rd);
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 5);
    axi_read(5'h10, 0, rd);
    axi_read(5'h00, 0, rd);

    axi_write(5'h14, 32'h0, 4'hF, 0);
`ifdef CMS_CTRL_TLAST_REG_EN
    check("tlast_zero", 64'(tlast_interval), 64'(1));
`else
    check("tlast_fixed", 64'(tlast_interval), 64'(TDEF));
`endif
    axi_read(5'h14, 0, rd);

    for (int k = 0; k < 300; k++) begin
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = 5'h0C;
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2), rd);
      check("tlast_track", 64'(tlast_interval), 64'(m_tlast));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // Reset asserted while the enable pulse is high
    repeat (8) @(negedge clk);
    axi_write(5'h0C, 32'h1, 4'hF, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!ctrl_write_enable && n < 10);
    check("pulse_before_reset", 64'(ctrl_write_enable), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    @(negedge clk);
    check("mid_rst_enable", 64'(ctrl_write_enable), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_tlast", 64'(tlast_interval), 64'(TDEF));
    rst_n = 1'b1;
    axi_read(5'h10, 0, rd);
    check("mid_rst_status", 64'(rd), 64'h0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
